// File: rtl/ysyx_041514_if_id.sv
// PC register and IF/ID pipeline register for the ysyx_041514 front end.
// Sequences the PC, inserts bubbles, honours back-pressure and holds redirects that arrive while stalled.
module ysyx_041514_if_id #(
   parameter int                 XLEN     = 64,
   parameter int                 INST_LEN = 32,
   parameter int                 TRAP_LEN = 32,
   parameter logic [XLEN-1:0]    RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [INST_LEN-1:0] INST_NOP = 32'h0000_0013
) (
   input  logic                clk,
   input  logic                rst,
   output logic [XLEN-1:0]     pc_o,
   input  logic [XLEN-1:0]     if_inst_addr_i,
   input  logic [INST_LEN-1:0] if_inst_data_i,
   input  logic [TRAP_LEN-1:0] if_trap_bus_i,
   input  logic                ram_stall_valid_if_i,
   input  logic                stall_valid_i,
   input  logic                redirect_valid_i,
   input  logic [XLEN-1:0]     redirect_pc_i,
   output logic [XLEN-1:0]     id_inst_addr_o,
   output logic [INST_LEN-1:0] id_inst_data_o,
   output logic [TRAP_LEN-1:0] id_trap_bus_o,
   output logic                id_inst_valid_o,
   output logic                redirect_pend_o,
   output logic [63:0]         if_inst_cnt_o
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

   logic [XLEN-1:0]     pc_r;
   logic [XLEN-1:0]     pend_pc_r;
   logic                pend_valid_r;
   logic [XLEN-1:0]     id_inst_addr_r;
   logic [INST_LEN-1:0] id_inst_data_r;
   logic [TRAP_LEN-1:0] id_trap_bus_r;
   logic                id_inst_valid_r;
   logic [63:0]         inst_cnt_r;

   logic                eff_redir_s;
   logic [XLEN-1:0]     eff_pc_s;

   // Merge a fresh redirect pulse with the latched one; the fresh pulse wins.
   always_comb begin
      eff_redir_s = redirect_valid_i | pend_valid_r;
      if (redirect_valid_i) begin
         eff_pc_s = redirect_pc_i;
      end else begin
         eff_pc_s = pend_pc_r;
      end
   end

   // PC sequencing, IF/ID capture and pending-redirect bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r            <= RESET_PC;
         pend_pc_r       <= '0;
         pend_valid_r    <= 1'b0;
         id_inst_addr_r  <= '0;
         id_inst_data_r  <= INST_NOP;
         id_trap_bus_r   <= '0;
         id_inst_valid_r <= 1'b0;
         inst_cnt_r      <= 64'd0;
      end else if (stall_valid_i) begin
         // Decode cannot accept; only remember the newest redirect target.
         if (redirect_valid_i) begin
            pend_valid_r <= 1'b1;
            pend_pc_r    <= redirect_pc_i;
         end
      end else if (eff_redir_s) begin
         pc_r            <= eff_pc_s;
         pend_valid_r    <= 1'b0;
         id_inst_addr_r  <= '0;
         id_inst_data_r  <= INST_NOP;
         id_trap_bus_r   <= '0;
         id_inst_valid_r <= 1'b0;
      end else if (ram_stall_valid_if_i) begin
         id_inst_addr_r  <= '0;
         id_inst_data_r  <= INST_NOP;
         id_trap_bus_r   <= '0;
         id_inst_valid_r <= 1'b0;
      end else begin
         pc_r            <= pc_r + PC_STEP;
         id_inst_addr_r  <= if_inst_addr_i;
         id_inst_data_r  <= if_inst_data_i;
         id_trap_bus_r   <= if_trap_bus_i;
         id_inst_valid_r <= 1'b1;
         inst_cnt_r      <= inst_cnt_r + 64'd1;
      end
   end

   assign pc_o            = pc_r;
   assign id_inst_addr_o  = id_inst_addr_r;
   assign id_inst_data_o  = id_inst_data_r;
   assign id_trap_bus_o   = id_trap_bus_r;
   assign id_inst_valid_o = id_inst_valid_r;
   assign redirect_pend_o = pend_valid_r;
   assign if_inst_cnt_o   = inst_cnt_r;

endmodule
